// File: rtl/whack_pkg.sv
// Shared constants, event kinds and the lowest-index picker for the whack detector.
package whack_pkg;

    localparam int NUM_MOLES_C = 16;
    localparam int SCORE_MAX_C = 9999;
    localparam int IDX_W_C     = 4;

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_HIT  = 2'd1,
        EV_MISS = 2'd2
    } ev_kind_e;

    function automatic logic [IDX_W_C-1:0] lowest_set_idx(input logic [NUM_MOLES_C-1:0] mask);
        logic [IDX_W_C-1:0] idx;
        idx = '0;
        // Walk downwards so the lowest set bit is the last one written.
        for (int i = NUM_MOLES_C - 1; i >= 0; i--) begin
            if (mask[i]) idx = IDX_W_C'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus tick-sampled debounce; emits a one-cycle flip per accepted switch change.
module switch_debouncer
    import whack_pkg::*;
#(
    parameter int N = NUM_MOLES_C
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         i_tick,
    input  logic [N-1:0] i_raw,
    output logic [N-1:0] o_deb,
    output logic [N-1:0] o_flip
);

    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;
    logic [N-1:0] r_snap;
    logic [N-1:0] r_deb;
    logic         r_init;
    logic [N-1:0] w_flip;

    // Accept a bit once it reads the same on two consecutive ticks and differs from the held value.
    assign w_flip = {N{i_tick & r_init}} & ~(r_sync2 ^ r_snap) & (r_sync2 ^ r_deb);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_snap  <= '0;
            r_deb   <= '0;
            r_init  <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (i_tick) begin
                r_snap <= r_sync2;
                if (!r_init) begin
                    r_deb  <= r_sync2;
                    r_init <= 1'b1;
                end else begin
                    r_deb <= r_deb ^ w_flip;
                end
            end
        end
    end

    assign o_deb  = r_deb;
    assign o_flip = w_flip;

endmodule

// File: rtl/whack_detector.sv
// Turns debounced switch flips into hit/miss events against the lit moles and keeps saturating scores.
// Optional WHACK_MISS_PENALTY_EN: each miss also takes one point off the hit count (floored at 0).
module whack_detector
    import whack_pkg::*;
#(
    parameter int NUM_MOLES       = NUM_MOLES_C,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int SCORE_MAX       = SCORE_MAX_C
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  logic [NUM_MOLES-1:0] moles_i,
    input  logic [NUM_MOLES-1:0] switches_i,
    output logic                 whack_o,
    output logic                 miss_o,
    output logic [IDX_W_C-1:0]   event_idx_o,
    output logic [NUM_MOLES-1:0] mole_clear_o,
    output logic [15:0]          hit_count_o,
    output logic [15:0]          miss_count_o
);

    localparam int                 PRESC_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0]        CNT_MAX    = 16'(SCORE_MAX);

    logic [PRESC_W-1:0]   r_presc;
    logic                 w_tick;
    logic [NUM_MOLES-1:0] w_flip;
    logic [NUM_MOLES-1:0] w_deb_unused;
    logic [NUM_MOLES-1:0] r_pending;
    logic [NUM_MOLES-1:0] w_serviced;
    logic [IDX_W_C-1:0]   w_sel_idx;
    ev_kind_e             w_kind;

    logic                 r_whack;
    logic                 r_miss;
    logic [IDX_W_C-1:0]   r_idx;
    logic [NUM_MOLES-1:0] r_mole_clear;
    logic [15:0]          r_hit_cnt;
    logic [15:0]          r_miss_cnt;

    assign w_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    switch_debouncer #(
        .N (NUM_MOLES)
    ) u_debouncer (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .i_tick  (w_tick),
        .i_raw   (switches_i),
        .o_deb   (w_deb_unused),
        .o_flip  (w_flip)
    );

    // One event per cycle: the lowest pending switch, classified against the mole pattern right now.
    always_comb begin
        w_sel_idx  = lowest_set_idx(r_pending);
        w_serviced = '0;
        w_kind     = EV_NONE;
        if (enable_i && (r_pending != '0)) begin
            w_serviced[w_sel_idx] = 1'b1;
            w_kind                = moles_i[w_sel_idx] ? EV_HIT : EV_MISS;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_pending    <= '0;
            r_whack      <= 1'b0;
            r_miss       <= 1'b0;
            r_idx        <= '0;
            r_mole_clear <= '0;
        end else begin
            if (!enable_i) begin
                r_pending <= '0;
            end else begin
                r_pending <= (r_pending & ~w_serviced) | w_flip;
            end
            r_whack      <= (w_kind == EV_HIT);
            r_miss       <= (w_kind == EV_MISS);
            r_mole_clear <= (w_kind == EV_HIT) ? w_serviced : '0;
            if (w_kind != EV_NONE) begin
                r_idx <= w_sel_idx;
            end
        end
    end

    // Clear wins over any score change landing in the same cycle.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (clear_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_kind == EV_HIT) begin
            if (r_hit_cnt < CNT_MAX) begin
                r_hit_cnt <= r_hit_cnt + 16'd1;
            end
        end else if (w_kind == EV_MISS) begin
            if (r_miss_cnt < CNT_MAX) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
`ifdef WHACK_MISS_PENALTY_EN
            if (r_hit_cnt != 16'd0) begin
                r_hit_cnt <= r_hit_cnt - 16'd1;
            end
`else
            r_hit_cnt <= r_hit_cnt;
`endif
        end
    end

    assign whack_o      = r_whack;
    assign miss_o       = r_miss;
    assign event_idx_o  = r_idx;
    assign mole_clear_o = r_mole_clear;
    assign hit_count_o  = r_hit_cnt;
    assign miss_count_o = r_miss_cnt;

endmodule
